ec_gpio_ctrl: RTL

Parametrised Avalon-MM general-purpose I/O controller for the Nios II SoC; next generation of the team's fixed 32-bit output/input port. Adds:
- configurable width;
- per-bit direction with tri-state enable;
- atomic set/clear of output bits;
- synchronised inputs, edge capture and a maskable level interrupt.

It sits on the system interconnect as a 32-bit slave, one per peripheral pin group.

---
 rtl/ec_gpio_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ec_gpio_ctrl.sv
// ec_gpio_ctrl: Avalon-MM GPIO controller with per-bit direction, atomic
// set/clear, synchronised inputs, sticky edge capture and maskable irq.
//
// Ports:
//   clk, reset_n          system clock, async active-low reset
//   address[2:0]          word address
//   chipselect, write_n   write when chipselect=1 and write_n=0
//   writedata[31:0]       write data (bits >= WIDTH ignored)
//   readdata[31:0]        registered read data, 1-cycle latency
//   in_port[WIDTH-1:0]    asynchronous pin inputs
//   out_port[WIDTH-1:0]   output data register
//   out_en[WIDTH-1:0]     per-bit output enable (DIRECTION)
//   irq                   registered level interrupt
module ec_gpio_ctrl #(
  parameter int unsigned       WIDTH       = 32,
  parameter logic [WIDTH-1:0]  DIR_RESET   = '0,
  parameter logic [WIDTH-1:0]  OUT_RESET   = '0,
  parameter int unsigned       EDGE_TYPE   = 0,
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] A_DATA     = 3'd0;
  localparam logic [2:0] A_DIR      = 3'd1;
  localparam logic [2:0] A_MASK     = 3'd2;
  localparam logic [2:0] A_EDGE     = 3'd3;
  localparam logic [2:0] A_OUTSET   = 3'd4;
  localparam logic [2:0] A_OUTCLEAR = 3'd5;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] irq_mask_q;
  logic [WIDTH-1:0] edge_cap_q;

  logic              wr_c;
  logic [WIDTH-1:0]  wdata_c;
  logic [WIDTH-1:0]  sync_c;
  logic [WIDTH-1:0]  edge_c;
  logic [WIDTH-1:0]  din_c;
  logic [WIDTH-1:0]  clr_c;
  logic [WIDTH-1:0]  out_nxt_c;
  logic [DATA_W-1:0] rd_nxt_c;

  assign wr_c    = chipselect & ~write_n;
  assign wdata_c = writedata[WIDTH-1:0];
  assign sync_c  = sync_q[SYNC_STAGES-1];

  // Input synchroniser chain followed by the edge-detect delay flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_c;
    end
  end

  // Per-bit edge detection on the synchronised value.
  always_comb begin
    edge_c = '0;
    case (EDGE_TYPE)
      0:       edge_c = sync_c & ~prev_q;
      1:       edge_c = ~sync_c & prev_q;
      default: edge_c = sync_c ^ prev_q;
    endcase
  end

  // DATA read view: driven bits show out_port, input bits show the pin.
  assign din_c = (out_port & out_en) | (sync_c & ~out_en);

  // Write-1-clear mask for EDGE_CAPTURE.
  assign clr_c = (wr_c && address == A_EDGE) ? wdata_c : '0;

  // Output register next value: load, atomic set, atomic clear.
  always_comb begin
    out_nxt_c = out_port;
    if (wr_c) begin
      case (address)
        A_DATA:     out_nxt_c = wdata_c;
        A_OUTSET:   out_nxt_c = out_port | wdata_c;
        A_OUTCLEAR: out_nxt_c = out_port & ~wdata_c;
        default:    out_nxt_c = out_port;
      endcase
    end
  end

  // Read mux; upper bits zero-extended.
  always_comb begin
    rd_nxt_c = '0;
    case (address)
      A_DATA:  rd_nxt_c = DATA_W'(din_c);
      A_DIR:   rd_nxt_c = DATA_W'(out_en);
      A_MASK:  rd_nxt_c = DATA_W'(irq_mask_q);
      A_EDGE:  rd_nxt_c = DATA_W'(edge_cap_q);
      default: rd_nxt_c = '0;
    endcase
  end

  // Register file, sticky capture (set beats clear) and irq.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port   <= OUT_RESET;
      out_en     <= DIR_RESET;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      irq        <= 1'b0;
      readdata   <= '0;
    end else begin
      out_port   <= out_nxt_c;
      if (wr_c && address == A_DIR)  out_en     <= wdata_c;
      if (wr_c && address == A_MASK) irq_mask_q <= wdata_c;
      edge_cap_q <= (edge_cap_q & ~clr_c) | edge_c;
      irq        <= |(edge_cap_q & irq_mask_q);
      readdata   <= rd_nxt_c;
    end
  end

endmodule
